mux_n_pipe: RTL and testbench

Parametrised, registered N-way operand selector with a valid/ready handshake on both sides; it generalises the 4-way 32-bit combinational operand multiplexer. A 2-entry skid buffer (main plus skid register) lets it sit between pipeline stages at full throughput, so operand selection can be moved off the critical path. An optional range check flags select codes that have no matching source when NUM_IN is not a power of two.

---
 rtl/mux_n_pipe.sv | 177 +++++++++++++++++
 tb/tb_mux_n_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mux_n_pipe
// Purpose  : Registered N-way operand selector with valid/ready handshake on
//            both sides. A 2-entry skid buffer (main + skid register) gives
//            full throughput while in_ready depends only on registered state.
// Ports    : clock, reset_n        - clock, asynchronous active-low reset
//            in_data, controle     - packed sources and source index
//            in_valid / in_ready   - upstream handshake
//            saida, out_sel        - selected word and its captured index
//            out_valid / out_ready - downstream handshake
//            flush                 - synchronous discard of buffered words
//            sel_erro              - sticky out-of-range select flag
// Options  : MUX_N_PIPE_SEL_CHECK_EN enables the sticky sel_erro flag;
//            otherwise sel_erro is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module mux_n_pipe #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        controle,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        saida,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    sel_erro
);

  // Occupancy of the two-entry buffer.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;
  logic [SEL_W-1:0] r_main_sel;
  logic [SEL_W-1:0] r_skid_sel;
  logic [WIDTH-1:0] w_sel_word;
  logic             w_accept;
  logic             w_pop;
  logic             w_load_main_in;
  logic             w_load_skid_in;
  logic             w_load_main_skid;

  // Handshake terms are derived from r_state directly so that neither side
  // sees a combinational path from the other side's ready/valid.
  assign w_accept = in_valid  && (r_state != S_TWO);
  assign w_pop    = out_ready && (r_state != S_EMPTY);

  // Source select; codes with no matching source yield 0.
  always_comb begin : p_select
    w_sel_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (controle == SEL_W'(i)) begin
        w_sel_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin : p_state_reg
    if (!reset_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides any transfer in the same cycle.
  always_comb begin : p_next_state
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_accept && !w_pop) begin
            w_state_nxt = S_TWO;
          end else if (!w_accept && w_pop) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO:   if (w_pop) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Output / load-enable decode.
  always_comb begin : p_outputs
    in_ready         = (r_state != S_TWO);
    out_valid        = (r_state != S_EMPTY);
    w_load_main_in   = 1'b0;
    w_load_skid_in   = 1'b0;
    w_load_main_skid = 1'b0;
    if (!flush) begin
      case (r_state)
        S_EMPTY: w_load_main_in = w_accept;
        S_ONE: begin
          // Simultaneous accept and pop replaces the head in place.
          w_load_main_in = w_accept && w_pop;
          w_load_skid_in = w_accept && !w_pop;
        end
        S_TWO:   w_load_main_skid = w_pop;
        default: ;
      endcase
    end
  end

  // Buffer registers. The main register is the head of the FIFO.
  always_ff @(posedge clock or negedge reset_n) begin : p_data_reg
    if (!reset_n) begin
      r_main_data <= '0;
      r_main_sel  <= '0;
      r_skid_data <= '0;
      r_skid_sel  <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_data <= w_sel_word;
        r_main_sel  <= controle;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_sel  <= r_skid_sel;
      end
      if (w_load_skid_in) begin
        r_skid_data <= w_sel_word;
        r_skid_sel  <= controle;
      end
    end
  end

  assign saida   = r_main_data;
  assign out_sel = r_main_sel;

`ifdef MUX_N_PIPE_SEL_CHECK_EN
  logic w_sel_bad;
  logic r_sel_erro;

  // A code is bad when it matches no source; constant 0 for power-of-two
  // NUM_IN because every code then has a source.
  always_comb begin : p_sel_bad
    w_sel_bad = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (controle == SEL_W'(i)) begin
        w_sel_bad = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin : p_sel_erro
    if (!reset_n) begin
      r_sel_erro <= 1'b0;
    end else if (flush) begin
      r_sel_erro <= 1'b0;
    end else if (w_accept && w_sel_bad) begin
      r_sel_erro <= 1'b1;
    end
  end

  assign sel_erro = r_sel_erro;
`else
  assign sel_erro = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_n_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_n_pipe
// Purpose  : Self-checking bench for mux_n_pipe. A 4-source instance is
//            tracked by an occupancy model with a scoreboard queue; a
//            3-source instance exercises the out-of-range select path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_n_pipe;

  localparam int W = 32;
`ifdef MUX_N_PIPE_SEL_CHECK_EN
  localparam logic C_ERR = 1'b1;
`else
  localparam logic C_ERR = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [W-1:0] src [4];

  // 4-source instance
  logic [4*W-1:0] in_data;
  logic [1:0]     controle;
  logic           in_valid, out_ready, flush;
  logic           in_ready, out_valid, sel_erro;
  logic [W-1:0]   saida;
  logic [1:0]     out_sel;

  // 3-source instance
  logic [3*W-1:0] in_data3;
  logic [1:0]     controle3;
  logic           in_valid3, out_ready3, flush3;
  logic           in_ready3, out_valid3, sel_erro3;
  logic [W-1:0]   saida3;
  logic [1:0]     out_sel3;

  assign in_data  = {src[3], src[2], src[1], src[0]};
  assign in_data3 = {src[2], src[1], src[0]};

  mux_n_pipe #(.WIDTH(W), .NUM_IN(4)) u_dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .controle(controle),
    .in_valid(in_valid), .in_ready(in_ready), .saida(saida), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .sel_erro(sel_erro)
  );

  mux_n_pipe #(.WIDTH(W), .NUM_IN(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .in_data(in_data3), .controle(controle3),
    .in_valid(in_valid3), .in_ready(in_ready3), .saida(saida3), .out_sel(out_sel3),
    .out_valid(out_valid3), .out_ready(out_ready3), .flush(flush3), .sel_erro(sel_erro3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Occupancy model and scoreboard for u_dut, evaluated mid-cycle.
  int           occ = 0;
  bit           acc_seen = 1'b0;
  logic [W+1:0] sb_q [$];

  always @(negedge clock) begin : p_model
    logic [W+1:0] head;
    bit acc, pop;
    acc_seen = 1'b0;
    if (!reset_n) begin
      occ = 0;
      sb_q.delete();
    end else begin
      check("in_ready", in_ready, occ != 2);
      check("out_valid", out_valid, occ != 0);
      check("sel_erro_pow2", sel_erro, 1'b0);
      if (occ != 0) begin
        head = sb_q[0];
        check("saida", saida, head[W-1:0]);
        check("out_sel", out_sel, head[W+1:W]);
      end
      acc = in_valid && (occ != 2);
      pop = out_ready && (occ != 0);
      if (flush) begin
        occ = 0;
        sb_q.delete();
      end else begin
        if (pop) begin
          void'(sb_q.pop_front());
          occ--;
        end
        if (acc) begin
          sb_q.push_back({controle, src[controle]});
          occ++;
          acc_seen = 1'b1;
        end
      end
    end
  end

  // Offer one word to u_dut and hold it until accepted (bounded).
  task automatic send(input logic [1:0] ctl);
    int n = 0;
    in_valid = 1'b1;
    controle = ctl;
    do begin
      @(posedge clock);
      n++;
    end while (!acc_seen && n < 20);
    check("send_timeout", acc_seen, 1'b1);
    #1;
    in_valid = 1'b0;
  endtask

  // One accepted transfer into u_dut3 (never backpressured: out_ready3=1).
  task automatic send3(input logic [1:0] ctl, input logic fl);
    in_valid3 = 1'b1;
    controle3 = ctl;
    flush3    = fl;
    @(posedge clock);
    #1;
    in_valid3 = 1'b0;
    flush3    = 1'b0;
  endtask

  initial begin
    src[0] = 32'h11111111;
    src[1] = 32'h22222222;
    src[2] = 32'h33333333;
    src[3] = 32'h44444444;
    in_valid  = 1'b0; out_ready  = 1'b0; flush  = 1'b0; controle  = 2'd0;
    in_valid3 = 1'b0; out_ready3 = 1'b1; flush3 = 1'b0; controle3 = 2'd0;

    // Reset state
    #7;
    check("rst_saida", saida, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sel_erro", sel_erro, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid3", out_valid3, 0);
    #5 reset_n = 1'b1;
    @(posedge clock); #1;

    // Basic select, back-to-back, out_ready high
    out_ready = 1'b1;
    send(2'd2);
    send(2'd0);
    repeat (3) @(posedge clock);
    #1;

    // Backpressure: A, B accepted; C held until release
    out_ready = 1'b0;
    send(2'd1);
    send(2'd3);
    in_valid = 1'b1;
    controle = 2'd2;
    repeat (2) begin
      @(posedge clock);
      check("c_blocked", acc_seen, 1'b0);
    end
    #1 out_ready = 1'b1;
    send(2'd2);
    repeat (4) @(posedge clock);
    #1;

    // Streaming: accept and pop every cycle
    for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)));
    repeat (3) @(posedge clock);
    #1;

    // Flush in TWO with a word on offer
    out_ready = 1'b0;
    send(2'd0);
    send(2'd3);
    in_valid = 1'b1;
    controle = 2'd1;
    flush    = 1'b1;
    @(posedge clock); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    @(posedge clock); #1;
    out_ready = 1'b1;
    send(2'd2);
    repeat (3) @(posedge clock);
    #1;

    // Range check on the 3-source instance
    send3(2'd3, 1'b0);
    @(negedge clock);
    check("bad_saida", saida3, 0);
    check("bad_out_sel", out_sel3, 3);
    check("bad_out_valid", out_valid3, 1);
    check("bad_sel_erro", sel_erro3, C_ERR);
    @(posedge clock); #1;
    send3(2'd1, 1'b0);
    @(negedge clock);
    check("good1_saida", saida3, src[1]);
    check("sticky_sel_erro", sel_erro3, C_ERR);
    @(posedge clock); #1;
    send3(2'd2, 1'b0);
    @(negedge clock);
    check("good2_saida", saida3, src[2]);
    check("sticky2_sel_erro", sel_erro3, C_ERR);
    @(posedge clock); #1;
    flush3 = 1'b1;
    @(posedge clock); #1;
    flush3 = 1'b0;
    @(negedge clock);
    check("flush_sel_erro", sel_erro3, 0);
    check("flush_out_valid3", out_valid3, 0);
    @(posedge clock); #1;
    send3(2'd3, 1'b1);
    @(negedge clock);
    check("flush_bad_sel_erro", sel_erro3, 0);
    check("flush_bad_out_valid3", out_valid3, 0);
    @(posedge clock); #1;

    // Asynchronous reset with two words buffered
    out_ready = 1'b0;
    send(2'd1);
    send(2'd2);
    send3(2'd3, 1'b0);
    @(negedge clock);
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_sel_erro3", sel_erro3, C_ERR);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_saida", saida, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_sel_erro3", sel_erro3, 0);
    check("arst_out_valid3", out_valid3, 0);
    check("arst_saida3", saida3, 0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b1;
    send(2'd3);
    @(negedge clock);
    check("post_rst_latency", out_valid, 1);
    check("post_rst_saida", saida, src[3]);
    repeat (3) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
